// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register with valid/ready handshake and a
// 2-entry skid buffer (main M drives out_*, skid S catches an entry while M
// stalls). in_ready is a flop, so there is no combinational ready path.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DEST_W-1:0] m_dest_q, m_dest_d, s_dest_q, s_dest_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic              acc, con;

  assign acc = in_valid & in_ready_q;
  assign con = m_valid_q & out_ready;

  // Next-state of M/S: flush kills both, otherwise fill M first, spill to S.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_dest_d  = m_dest_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_dest_d  = s_dest_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
    end else if (!m_valid_q) begin
      if (acc) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_dest_d  = in_dest;
        m_data_d  = in_data;
      end
    end else if (con) begin
      if (s_valid_q) begin
        // S full implies in_ready was 0, so nothing new arrives here.
        m_ctrl_d  = s_ctrl_q;
        m_dest_d  = s_dest_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_ctrl_d = in_ctrl;
        m_dest_d = in_dest;
        m_data_d = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_dest_d  = in_dest;
      s_data_d  = in_data;
    end
    in_ready_d = ~s_valid_d;
  end

  // State registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q  <= 1'b0;
      m_ctrl_q   <= '0;
      m_dest_q   <= '0;
      m_data_q   <= '0;
      s_valid_q  <= 1'b0;
      s_ctrl_q   <= '0;
      s_dest_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_ctrl_q   <= m_ctrl_d;
      m_dest_q   <= m_dest_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_ctrl_q   <= s_ctrl_d;
      s_dest_q   <= s_dest_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  // Bubbles carry zero control so downstream enables stay inert.
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign out_dest  = m_dest_q;
  assign out_data  = m_data_q;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && (m_valid_q || s_valid_q) && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted entries are queued, each
// consumed output is popped and compared; perf counters follow a small model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_ctrl = '0;
  logic [4:0]  in_dest = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_dest;
  logic [31:0] out_data;
  logic [15:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [2:0]  c;
    logic [4:0]  d;
    logic [31:0] x;
  } ent_t;

  ent_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_stall = '0;
  logic [15:0] exp_flush = '0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(3), .DEST_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_dest(in_dest), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_dest(out_dest), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: score the cycle at negedge, then step past the next posedge.
  task automatic cyc();
    ent_t e;
    @(negedge clk);
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
    if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    if (!rst) begin
      sb.delete();
      exp_stall = '0;
      exp_flush = '0;
    end else begin
`ifdef PIPE_PERF_CNT_EN
      if (out_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
      if (flush && out_valid && exp_flush != 16'hFFFF) exp_flush++;
`endif
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
            chk("out_dest", 64'(out_dest), 64'(e.d));
            chk("out_data", 64'(out_data), 64'(e.x));
          end
        end
        if (in_valid && in_ready) sb.push_back('{c: in_ctrl, d: in_dest, x: in_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [4:0] d, input logic [31:0] x);
    in_valid = v;
    in_ctrl  = c;
    in_dest  = d;
    in_data  = x;
  endtask

  initial begin
    // Reset with an entry offered: nothing may be captured.
    drive(1'b1, 3'b111, 5'd7, 32'hDEAD);
    cyc();
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 5'd3, 32'h55);
    cyc();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data", 64'(out_data), 64'h55);

    // Streaming with one-cycle latency.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b010, 5'(i), 32'h10 + 32'(i));
      cyc();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_data), 64'h10 + 64'(i));
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    cyc();
    chk("stream_empty", 64'(out_valid), 64'd0);

    // Back-pressure: A in M, B in S, C must wait.
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 5'd10, 32'hA);
    cyc();
    drive(1'b1, 3'b100, 5'd11, 32'hB);
    cyc();
    chk("bp_data_a", 64'(out_data), 64'hA);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 3'b100, 5'd12, 32'hC);
    cyc();
    cyc();
    chk("bp_hold_a", 64'(out_data), 64'hA);
    chk("bp_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("bp_data_b", 64'(out_data), 64'hB);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    cyc();
    chk("bp_data_c", 64'(out_data), 64'hC);
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    cyc();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset while both entries are held.
    out_ready = 1'b0;
    drive(1'b1, 3'b011, 5'd1, 32'h31);
    cyc();
    drive(1'b1, 3'b011, 5'd2, 32'h32);
    cyc();
    chk("rs_full", 64'(in_ready), 64'd0);
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("rs_no_stale", 64'(out_valid), 64'd0);

    // Flush of a full stage, with an entry offered in the flush cycle.
    out_ready = 1'b0;
    drive(1'b1, 3'b101, 5'd4, 32'h21);
    cyc();
    drive(1'b1, 3'b101, 5'd5, 32'h22);
    cyc();
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    repeat (4) cyc();
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b101, 5'd6, 32'hF);
    cyc();
    flush = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_PERF_CNT_EN
    chk("fl_stall5", 64'(stall_cnt), 64'd5);
    chk("fl_flush1", 64'(flush_cnt), 64'd1);
`else
    chk("fl_stall0", 64'(stall_cnt), 64'd0);
    chk("fl_flush0", 64'(flush_cnt), 64'd0);
`endif
    repeat (3) cyc();
    chk("fl_no_f", 64'(out_valid), 64'd0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 5'($urandom), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      cyc();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    repeat (3) cyc();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_empty", 64'(out_valid), 64'd0);

`ifdef PIPE_PERF_CNT_EN
    // Stall long enough to saturate the 16-bit counter.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 5'd1, 32'h77);
    cyc();
    drive(1'b0, 3'b000, 5'd0, 32'h0);
    repeat (70000) cyc();
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the CAP19 pipeline, the generalised successor of the fixed EXE/MEM latch.
- Carries a control bundle (WB/MEM enables), a destination register address and a data payload (PC, ALU result, store value, etc., concatenated by the instantiator).
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure without combinational ready paths, and flush.
- Instantiated between any two stages (ID/EXE, EXE/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits; 1..256.
- CTRL_W, 3, control-bit bundle width (e.g. {WB_EN, MEM_R_EN, MEM_W_EN}); 1..16.
- DEST_W, 5, destination register address width; same as REG_FILE_ADDR_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (sampled on posedge clk; 0 = reset).
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept this cycle (registered).
- in_ctrl  input  CTRL_W  control bundle.
- in_dest  input  DEST_W  destination register.
- in_data  input  DATA_W  payload.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream consumes the main entry this cycle.
- out_ctrl  output  CTRL_W  control bundle; forced 0 when out_valid=0.
- out_dest  output  DEST_W  destination register.
- out_data  output  DATA_W  payload.
- stall_cnt  output  16  perf counter (see Optional Feature).
- flush_cnt  output  16  perf counter (see Optional Feature).

Behaviour:
- Storage: main register M (drives the out_* ports) and skid register S. Each has a valid bit.
- Accept condition: acc = in_valid & in_ready. Consume condition: con = out_valid & out_ready.
- Reset (rst=0 at posedge), all registers:
  - M.valid=0, S.valid=0, in_ready=1.
  - out_ctrl=0, out_dest=0, out_data=0.
  - S contents=0, both counters=0.
  - Reset overrides flush and the handshake. Reset mid-transfer discards M and S.
- Flush (rst=1, flush=1):
  - M.valid=0, S.valid=0, in_ready=1.
  - M.ctrl and S.ctrl are zeroed. Dest and data hold their values (don't-care).
  - Any entry offered in the same cycle is dropped. Flush beats out_ready.
- Normal operation (rst=1, flush=0), per posedge:
  - M invalid: if acc, load M from in_*.
  - M valid and con, S valid: M<=S, S.valid=0.
  - M valid and con, S invalid: if acc, M<=in; else M.valid=0.
  - M valid and !con: if acc, S<=in, S.valid=1; M holds.
- in_ready next = !(S.valid next). It is never derived combinationally from out_ready.
- Latency: an entry accepted on edge n is presented on out_* after edge n (1 cycle) when M was empty or consumed.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush or reset.
- Capacity: 2 entries. With both full, in_ready=0; simultaneous in_valid is ignored.
- When out_valid=0, out_ctrl reads 0 so downstream write/memory enables are inert. This replaces explicit bubble injection.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - flush_cnt increments by 1 for each flush cycle in which M.valid|S.valid was 1.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear only on reset.
- Undefined: no counter logic is built; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1, in_ctrl=3'b111 -> out_valid=0, out_ctrl=0, in_ready=1; after release, the first accepted entry appears 1 cycle later.
- Streaming: out_ready=1, entries data=0x10,0x11,0x12 on consecutive cycles -> same values on out_data on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Back-pressure: push A=0xA, B=0xB with out_ready=0 -> out_data=0xA, S=B, in_ready=0; C held on input is not accepted; set out_ready=1 -> outputs A, B, C in order, in_ready returns 1 one cycle after S drains.
- Flush: M and S full (ctrl=3'b101), flush=1 with in_valid=1, data=0xF -> next cycle out_valid=0, out_ctrl=0, in_ready=1, 0xF never appears.
- Reset mid-stall: both entries full, rst=0 one cycle -> empty, in_ready=1, and no stale entry reappears.
- PIPE_PERF_CNT_EN defined: 5 stall cycles then one flush of a full stage -> stall_cnt=5, flush_cnt=1. Force 70000 stall cycles -> stall_cnt=16'hFFFF. Macro undefined -> both counters read 0 throughout.
